// File: rtl/q_change_logger.sv
// rtl/q_change_logger.sv - samples a q bus, timestamps value changes and queues them for a valid/ready consumer
module q_change_logger #(
  parameter int WIDTH = 4,
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       mon_en,
  input  logic [WIDTH-1:0]           q_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_value,
  output logic [TS_W-1:0]            out_time,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + TS_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Free-running cycle stamp and change-detect history
  logic [TS_W-1:0]  ts;
  logic             primed;
  logic [WIDTH-1:0] prev;

  // FIFO storage and pointers; the extra pointer bit separates full from empty
  logic [EW-1:0]    mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Per-cycle decisions
  logic             event_hit;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;
  logic [AW:0]      rd_next;
  logic [AW:0]      wr_next;
  logic [AW:0]      cnt_next;
  logic             new_is_head;
  logic [EW-1:0]    push_entry;

  assign count = wr_ptr - rd_ptr;

  // Classify this edge: detect a change, decide push/pop/drop and the next head source
  always_comb begin
    event_hit   = 1'b0;
    full        = 1'b0;
    do_pop      = 1'b0;
    do_push     = 1'b0;
    drop        = 1'b0;
    rd_next     = rd_ptr;
    wr_next     = wr_ptr;
    cnt_next    = count;
    new_is_head = 1'b0;
    push_entry  = {q_in, ts};

    event_hit = mon_en && primed && (q_in != prev);
    full      = (count == FULL_CNT);
    do_pop    = out_valid && out_ready;
    // A pop in the same cycle frees the slot the new entry needs
    do_push   = event_hit && (!full || do_pop);
    drop      = event_hit && full && !do_pop;

    if (do_pop) begin
      rd_next = rd_ptr + (AW+1)'(1);
    end
    if (do_push) begin
      wr_next = wr_ptr + (AW+1)'(1);
    end
    cnt_next = wr_next - rd_next;

    // The pushed entry lands exactly where the next read pointer points only
    // when everything older has been consumed
    new_is_head = do_push && (rd_next == wr_ptr);
  end

  // Timestamp counts every cycle out of reset, independent of monitoring
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // Priming and previous-value tracking; dropping mon_en forces a re-prime
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      primed <= 1'b0;
      prev   <= '0;
    end else begin
      primed <= mon_en;
      if (mon_en) begin
        prev <= q_in;
      end
    end
  end

  // FIFO data array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  // Pointer updates
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
    end
  end

  // Registered head: loads the new head entry, holds last values while empty
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_time  <= '0;
    end else begin
      out_valid <= (cnt_next != '0);
      if (new_is_head) begin
        out_value <= q_in;
        out_time  <= ts;
      end else if (cnt_next != '0) begin
        {out_value, out_time} <= mem[rd_next[AW-1:0]];
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_q_change_logger.sv
// tb/tb_q_change_logger.sv - scoreboard bench for q_change_logger
module tb_q_change_logger;

  localparam int WIDTH = 4;
  localparam int TS_W  = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             arst;
  logic             mon_en;
  logic [WIDTH-1:0] q_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic [TS_W-1:0]  out_time;
  logic [2:0]       count;
  logic             overflow;
  logic             ovf_clr;

  q_change_logger #(.WIDTH(WIDTH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .arst(arst),
    .mon_en(mon_en),
    .q_in(q_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_time(out_time),
    .count(count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected {value, time} entries plus reference state
  logic [WIDTH+TS_W-1:0] sb [$];
  logic [TS_W-1:0]       m_ts;
  logic                  m_primed;
  logic [WIDTH-1:0]      m_prev;
  logic                  m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ts     = '0;
    m_primed = 1'b0;
    m_prev   = '0;
    m_ovf    = 1'b0;
  endtask

  // Predict the coming rising edge from the current inputs, cross it, then check
  task automatic tick();
    logic                  pop;
    logic                  ev;
    logic                  dropped;
    logic [WIDTH+TS_W-1:0] h;
    pop     = (sb.size() > 0) && out_ready;
    ev      = mon_en && m_primed && (q_in != m_prev);
    dropped = 1'b0;
    if (pop) begin
      h = sb.pop_front();
      check_eq("head_value", 32'(out_value), 32'(h[WIDTH+TS_W-1:TS_W]));
      check_eq("head_time", 32'(out_time), 32'(h[TS_W-1:0]));
    end
    if (ev) begin
      if (sb.size() < DEPTH) sb.push_back({q_in, m_ts});
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_primed = mon_en;
    if (mon_en) m_prev = q_in;
    m_ts = m_ts + 8'd1;
    @(posedge clk);
    @(negedge clk);
    check_eq("count", 32'(count), 32'(sb.size()));
    check_eq("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    arst      = 1'b1;
    mon_en    = 1'b0;
    q_in      = 4'b1010;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    #1;
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_value", 32'(out_value), 0);
    check_eq("rst_time", 32'(out_time), 0);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;

    // Priming with constant input: nothing logged
    mon_en = 1'b1;
    ticks(3);
    // Disable, change input, re-enable: re-prime without stale event
    mon_en = 1'b0;
    q_in   = 4'h0;
    tick();
    mon_en = 1'b1;
    ticks(3);

    // Single change at timestamp 7
    q_in = 4'hA;
    tick();
    check_eq("single_value", 32'(out_value), 32'hA);
    check_eq("single_time", 32'(out_time), 7);
    check_eq("single_count", 32'(count), 1);
    out_ready = 1'b1;
    tick();
    check_eq("empty_hold_value", 32'(out_value), 32'hA);
    check_eq("empty_hold_time", 32'(out_time), 7);

    // Glitch inside a cycle is invisible; a pulse spanning an edge logs twice
    q_in = 4'h0;
    ticks(3);
    q_in = 4'hA;
    #3;
    q_in = 4'h0;
    tick();
    check_eq("glitch_count", 32'(count), 0);
    out_ready = 1'b0;
    q_in = 4'hA;
    tick();
    q_in = 4'h0;
    tick();
    out_ready = 1'b1;
    ticks(3);

    // Fill and overflow
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      q_in = 4'(v);
      tick();
    end
    check_eq("full_count", 32'(count), 4);
    check_eq("full_ovf", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 0);

    // Full with concurrent pop accepts the push
    out_ready = 1'b1;
    q_in      = 4'h6;
    tick();
    out_ready = 1'b0;
    check_eq("full_pop_count", 32'(count), 4);
    check_eq("full_pop_ovf", 32'(overflow), 0);

    // Drop and clear on the same edge: set wins
    q_in    = 4'h7;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("set_wins", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Drain
    out_ready = 1'b1;
    ticks(5);

    // Timestamp wrap
    while (m_ts != 8'd255) tick();
    out_ready = 1'b0;
    q_in = 4'h8;
    tick();
    check_eq("wrap_t255", 32'(out_time), 255);
    q_in = 4'h9;
    tick();
    out_ready = 1'b1;
    ticks(2);
    out_ready = 1'b0;
    for (int v = 10; v <= 12; v++) begin
      q_in = 4'(v);
      tick();
    end
    check_eq("pre_reset_count", 32'(count), 3);

    // Mid-stream reset discards everything immediately
    arst = 1'b1;
    #1;
    check_eq("midrst_count", 32'(count), 0);
    check_eq("midrst_valid", 32'(out_valid), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    ticks(3);
    q_in = 4'h3;
    tick();
    check_eq("post_rst_value", 32'(out_value), 32'h3);
    check_eq("post_rst_time", 32'(out_time), 3);
    out_ready = 1'b1;
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
